// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage: datapath widths and the
// load-type encoding used by the memory stage.
package wb_stage_pkg;

  localparam int ISA_WIDTH           = 32;
  localparam int REG_FILE_ADDR_WIDTH = 5;

  // Load encodings; codes 101..111 are reserved and behave as LOAD_LW.
  typedef enum logic [2:0] {
    LOAD_LW  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LHU = 3'b010,
    LOAD_LB  = 3'b011,
    LOAD_LBU = 3'b100
  } load_type_e;

  // True for the halfword loads, which need a 2-byte aligned address.
  function automatic logic is_half_load(input logic [2:0] load_type);
    return (load_type == LOAD_LH) || (load_type == LOAD_LHU);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB bus: the memory-stage slot contents and pipeline control going
// in, register-file write port and status coming out.
//
// Handshake: there is no valid/ready pair here. mem_valid only qualifies
// the MEM slot contents; the stage never back-pressures. stall holds the
// WB register contents, flush replaces them with a bubble (flush wins).
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = ISA_WIDTH,
  parameter int ADDR_WIDTH = REG_FILE_ADDR_WIDTH
) ();

  logic                  stall;
  logic                  flush;
  logic                  mem_valid;
  logic                  mem_reg_write;
  logic [ADDR_WIDTH-1:0] mem_reg_addr;
  logic                  mem_mem_to_reg;
  logic                  mem_link;
  logic [2:0]            mem_load_type;
  logic [1:0]            mem_byte_off;
  logic [DATA_WIDTH-1:0] mem_alu_result;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic [DATA_WIDTH-1:0] mem_pc_plus_8;

  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_reg_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  wb_valid;
  logic                  misalign_err;

  // Pipeline side that produces the MEM slot.
  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_reg_addr,
           mem_mem_to_reg, mem_link, mem_load_type, mem_byte_off,
           mem_alu_result, mem_read_data, mem_pc_plus_8,
    input  write_en, write_reg_addr, write_data, wb_valid, misalign_err
  );

  // The writeback stage itself.
  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_reg_addr,
           mem_mem_to_reg, mem_link, mem_load_type, mem_byte_off,
           mem_alu_result, mem_read_data, mem_pc_plus_8,
    output write_en, write_reg_addr, write_data, wb_valid, misalign_err
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of
// the raw little-endian memory word, extends it, and flags addresses that
// are not naturally aligned for the access size.
module wb_stage_load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = ISA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  logic [1:0]            byte_off,
  input  logic [2:0]            load_type,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane select, extension and alignment check.
  always_comb begin
    sel_byte   = raw[7:0];
    sel_half   = byte_off[1] ? raw[31:16] : raw[15:0];
    data       = raw;
    misaligned = 1'b0;
    case (byte_off)
      2'd0:    sel_byte = raw[7:0];
      2'd1:    sel_byte = raw[15:8];
      2'd2:    sel_byte = raw[23:16];
      default: sel_byte = raw[31:24];
    endcase
    case (load_type)
      LOAD_LB:  data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      LOAD_LBU: data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      LOAD_LH:  data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
      LOAD_LHU: data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
      // LW and the reserved codes take the whole word.
      default:  data = raw;
    endcase
    if (is_half_load(load_type)) begin
      misaligned = byte_off[0];
    end else if ((load_type != LOAD_LB) && (load_type != LOAD_LBU)) begin
      misaligned = (byte_off != 2'b00);
    end
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback select. Registers the MEM slot,
// aligns loads, and drives the register-file write port. The register
// file commits on negedge, so results registered here are readable by ID
// in the second half of the same cycle.
//
// Optional feature macro: WB_RETIRE_CNT_EN adds a 32-bit retire_cnt output
// counting every posedge that loads a valid MEM slot.
//
// Note: rst_n is an active-HIGH synchronous reset; the name is historical.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = ISA_WIDTH,
  parameter int ADDR_WIDTH = REG_FILE_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_stage_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  logic [DATA_WIDTH-1:0] aligned_data;
  logic                  align_mis;
  logic                  misaligned_load;
  logic [DATA_WIDTH-1:0] result;
  logic                  reg_we;

  logic                  en_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  mis_r;

  wb_stage_load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .raw        (bus.mem_read_data),
    .byte_off   (bus.mem_byte_off),
    .load_type  (bus.mem_load_type),
    .data       (aligned_data),
    .misaligned (align_mis)
  );

  // Result select (link beats load beats ALU) and write-enable qualify.
  always_comb begin
    misaligned_load = bus.mem_mem_to_reg & align_mis;
    if (bus.mem_link) begin
      result = bus.mem_pc_plus_8;
    end else if (bus.mem_mem_to_reg) begin
      result = aligned_data;
    end else begin
      result = bus.mem_alu_result;
    end
    reg_we = bus.mem_valid & bus.mem_reg_write &
             (bus.mem_reg_addr != '0) & ~misaligned_load;
  end

  // WB register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      en_r    <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      mis_r   <= 1'b0;
    end else if (bus.flush) begin
      en_r    <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      mis_r   <= 1'b0;
    end else if (bus.stall) begin
      // Hold everything, but drop the error so it stays a single pulse.
      mis_r   <= 1'b0;
    end else begin
      en_r    <= reg_we;
      addr_r  <= bus.mem_reg_addr;
      data_r  <= result;
      valid_r <= bus.mem_valid;
      mis_r   <= misaligned_load;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_r;

  // Count retiring instructions: only loading posedges with a valid slot.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_r <= '0;
    end else if (!bus.flush && !bus.stall && bus.mem_valid) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign retire_cnt = cnt_r;
`endif

  assign bus.write_en       = en_r;
  assign bus.write_reg_addr = addr_r;
  assign bus.write_data     = data_r;
  assign bus.wb_valid       = valid_r;
  assign bus.misalign_err   = mis_r;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback select for the 5-stage CPU.
- Captures the memory-stage result, performs load byte/halfword alignment and sign extension, and picks the ALU, load or link value.
- Drives the register file write port: write_en, write_reg_addr and write_data.
- The register file commits on negedge clk, so a value registered here at posedge N is readable by ID in the second half of cycle N.

Parameters:
- DATA_WIDTH, 32: datapath width; equals ISA_WIDTH.
- ADDR_WIDTH, 5: register index width; equals REG_FILE_ADDR_WIDTH.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  synchronous reset, active-HIGH despite the name (codebase port name kept).
- stall  in  1  hold current WB contents.
- flush  in  1  load a bubble.
- mem_valid  in  1  MEM slot holds a real instruction.
- mem_reg_write  in  1  instruction writes a GPR.
- mem_reg_addr  in  ADDR_WIDTH  destination GPR.
- mem_mem_to_reg  in  1  result comes from load data.
- mem_link  in  1  result is mem_pc_plus_8 (jal/jalr).
- mem_load_type  in  3  load encoding, see Decomposition.
- mem_byte_off  in  2  effective address bits [1:0].
- mem_alu_result  in  DATA_WIDTH  ALU result.
- mem_read_data  in  DATA_WIDTH  raw data-memory word.
- mem_pc_plus_8  in  DATA_WIDTH  link value.
- write_en  out  1  to register file.
- write_reg_addr  out  ADDR_WIDTH  to register file.
- write_data  out  DATA_WIDTH  to register file; also the forwarding source.
- wb_valid  out  1  WB slot holds a retiring instruction.
- misalign_err  out  1  one-cycle pulse: misaligned load suppressed.

Behaviour:
- Latency: 1 cycle. Inputs sampled at posedge N appear on the outputs after posedge N.
- Priority each posedge: rst_n > flush > stall > load.
  - rst_n: all outputs and state 0 (write_en=0, write_reg_addr=0, write_data=0, wb_valid=0, misalign_err=0).
  - flush: bubble (wb_valid=0, write_en=0, addr/data=0, misalign_err=0). Flush during stall still bubbles.
  - stall: all registers hold; misalign_err forced 0 so the pulse never repeats. Repeated negedge writes of the same value are legal.
  - load: wb_valid <= mem_valid; result registered as follows.
- write_data select: mem_link ? mem_pc_plus_8 : mem_mem_to_reg ? aligned_load : mem_alu_result. mem_link has priority over mem_mem_to_reg.
- Load alignment, little-endian, byte k = bits [8k+7:8k]:
  - LB/LBU: byte mem_byte_off, sign- or zero-extended to 32 bits.
  - LH/LHU: halfword at mem_byte_off[1].
  - LW: full word.
- Misaligned load:
  - Condition: LH/LHU with mem_byte_off[0]=1, or LW with mem_byte_off!=0, and mem_mem_to_reg=1.
  - Effect: write_en <= 0, misalign_err <= 1 for one cycle, wb_valid <= mem_valid (instruction still retires).
- write_en <= mem_valid & mem_reg_write & (mem_reg_addr != 0) & ~misaligned. A $0 destination never asserts write_en.
- Invalid slot (mem_valid=0): write_en=0; addr/data registered but ignored.
- Reserved load_type codes 101..111 decode as LW.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt, 32 bits.
  - Increments by 1 on each posedge that performs a load with mem_valid=1. It does not increment on stall, flush or reset.
  - Reset value 0; wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared constants in definitions.v:
  - LOAD_LW=3'b000, LOAD_LH=3'b001, LOAD_LHU=3'b010, LOAD_LB=3'b011, LOAD_LBU=3'b100.
  - Reuse ISA_WIDTH and REG_FILE_ADDR_WIDTH.
- Sub-module load_align: combinational.
  - Inputs: raw word, byte_off, load_type.
  - Outputs: aligned data, misaligned flag.
  - Instanced once in wb_stage.

Test Plan:
- Reset: rst_n=1 for 2 cycles with random mem_* inputs -> write_en=0, write_reg_addr=0, write_data=0, wb_valid=0, misalign_err=0 each cycle.
- ALU and $0:
  - valid, reg_write, addr=5, alu_result=0x1234ABCD -> next cycle write_en=1, addr=5, data=0x1234ABCD; register file reads 0x1234ABCD in the same cycle.
  - Same with addr=0 -> write_en=0.
- Loads, read_data=0x80FF7F01:
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=3 -> 0x00000080.
  - LH off=0 -> 0x00007F01.
  - LH off=2 -> 0xFFFF80FF.
  - LW off=0 -> 0x80FF7F01.
- Misaligned: LW off=1, addr=7 -> write_en=0, misalign_err=1 for exactly 1 cycle, wb_valid=1. Holding stall afterwards keeps misalign_err=0.
- Stall/flush:
  - Load a result, stall 3 cycles -> outputs constant.
  - Assert flush together with stall -> bubble next cycle.
  - With WB_RETIRE_CNT_EN: retire_cnt increments once for the stalled instruction and not for the flush.
- Link: mem_link=1, mem_mem_to_reg=1, addr=31, pc_plus_8=0x00400010 -> write_data=0x00400010, write_en=1.
